// File: rtl/spart_driver.sv
// spart_driver: programs the SPART baud divisor from br_cfg, then echoes
// every received byte back out through the same SPART.
module spart_driver #(
    parameter logic [15:0] DIV_4800  = 16'h28B1,
    parameter logic [15:0] DIV_9600  = 16'h1458,
    parameter logic [15:0] DIV_19200 = 16'h0A2C,
    parameter logic [15:0] DIV_38400 = 16'h0516
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    output logic [7:0] db_out,
    output logic       db_oe,
    input  logic [7:0] db_in,
    output logic [7:0] echo_cnt
);

    typedef enum logic [2:0] {
        INIT_LOW,
        INIT_HIGH,
        POLL_RX,
        READ_RX,
        POLL_TX,
        WRITE_TX
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  cfg_q;
    logic [1:0]  cfg_nxt;
    logic [7:0]  rx_hold;
    logic        held;
    logic [15:0] divisor_nxt;

    // Next state and baud selection; `held` marks the idle bus cycle that
    // follows a reset edge, after which INIT_LOW is actually issued.
    always_comb begin
        state_nxt = state;
        cfg_nxt   = cfg_q;
        if (held) begin
            state_nxt = INIT_LOW;
        end else begin
            case (state)
                INIT_LOW:  state_nxt = INIT_HIGH;
                INIT_HIGH: state_nxt = POLL_RX;
                POLL_RX: begin
                    if (br_cfg != cfg_q) begin
                        state_nxt = INIT_LOW;
                        cfg_nxt   = br_cfg;
                    end else if (db_in[0]) begin
                        state_nxt = READ_RX;
                    end
                end
                READ_RX:   state_nxt = POLL_TX;
                POLL_TX:   if (db_in[1]) state_nxt = WRITE_TX;
                WRITE_TX:  state_nxt = POLL_RX;
                default:   state_nxt = INIT_LOW;
            endcase
        end

        case (cfg_nxt)
            2'b00:   divisor_nxt = DIV_4800;
            2'b01:   divisor_nxt = DIV_9600;
            2'b10:   divisor_nxt = DIV_19200;
            default: divisor_nxt = DIV_38400;
        endcase
    end

    // State, data registers and the bus access for the state being entered,
    // so every output is a register and db_in never reaches an output directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= INIT_LOW;
            held     <= 1'b1;
            cfg_q    <= br_cfg;
            rx_hold  <= '0;
            echo_cnt <= '0;
            iocs     <= 1'b0;
            iorw     <= 1'b1;
            ioaddr   <= 2'b00;
            db_oe    <= 1'b0;
            db_out   <= '0;
        end else begin
            held  <= 1'b0;
            state <= state_nxt;
            cfg_q <= cfg_nxt;
            if (!held && state == READ_RX) begin
                rx_hold <= db_in;
            end
            if (state_nxt == WRITE_TX) begin
                echo_cnt <= echo_cnt + 8'd1;
            end

            iocs   <= 1'b1;
            iorw   <= 1'b1;
            ioaddr <= 2'b00;
            db_oe  <= 1'b0;
            db_out <= '0;
            case (state_nxt)
                INIT_LOW: begin
                    iorw   <= 1'b0;
                    ioaddr <= 2'b10;
                    db_oe  <= 1'b1;
                    db_out <= divisor_nxt[7:0];
                end
                INIT_HIGH: begin
                    iorw   <= 1'b0;
                    ioaddr <= 2'b11;
                    db_oe  <= 1'b1;
                    db_out <= divisor_nxt[15:8];
                end
                POLL_RX, POLL_TX: begin
                    ioaddr <= 2'b01;
                end
                READ_RX: begin
                    ioaddr <= 2'b00;
                end
                WRITE_TX: begin
                    iorw   <= 1'b0;
                    ioaddr <= 2'b00;
                    db_oe  <= 1'b1;
                    db_out <= rx_hold;
                end
                default: begin
                    iocs <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spart_driver.sv
// Testbench for spart_driver: a small reactive SPART model answers status and
// rx reads; expected bus writes are queued and compared as they appear.
module tb_spart_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] br_cfg = 2'b01;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic [7:0] db_out;
    logic       db_oe;
    logic [7:0] db_in = 8'h00;
    logic [7:0] echo_cnt;

    int unsigned passed = 0;
    int unsigned total  = 0;

    // SPART model state
    logic       rx_avail = 1'b0;
    logic [7:0] rx_byte  = 8'h00;
    logic       tbr      = 1'b1;
    logic [9:0] exp_q[$];

    spart_driver #(
        .DIV_4800 (16'h28B1),
        .DIV_9600 (16'h1458),
        .DIV_19200(16'h0A2C),
        .DIV_38400(16'h0516)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .br_cfg  (br_cfg),
        .iocs    (iocs),
        .iorw    (iorw),
        .ioaddr  (ioaddr),
        .db_out  (db_out),
        .db_oe   (db_oe),
        .db_in   (db_in),
        .echo_cnt(echo_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passed, total);
        $fatal(1, "watchdog");
    end

    // One bus cycle: sample the access after the edge and answer it on db_in.
    task automatic tick(output logic wr, output logic rd, output logic [9:0] wv);
        @(posedge clk);
        #1;
        wr = iocs && !iorw;
        rd = iocs && iorw && (ioaddr == 2'b00);
        wv = {ioaddr, db_out};
        if (iocs && iorw && ioaddr == 2'b01) begin
            db_in = {6'($urandom), tbr, rx_avail};
        end else if (rd) begin
            db_in    = rx_byte;
            rx_avail = 1'b0;
        end else begin
            db_in = 8'($urandom);
        end
    endtask

    task automatic test_reset();
        logic wr, rd;
        logic [9:0] wv, e;
        rst = 1'b1;
        br_cfg = 2'b01;
        tick(wr, rd, wv);
        tick(wr, rd, wv);
        total++;
        if ({iocs, iorw, ioaddr, db_oe, db_out} !== {1'b0, 1'b1, 2'b00, 1'b0, 8'h00})
            $display("FAIL reset_bus: got %b required %b",
                     {iocs, iorw, ioaddr, db_oe, db_out}, {1'b0, 1'b1, 2'b00, 1'b0, 8'h00});
        else passed++;
        total++;
        if (echo_cnt !== 8'h00) $display("FAIL reset_cnt: got %h required 00", echo_cnt);
        else passed++;

        exp_q.delete();
        exp_q.push_back({2'b10, 8'h58});
        exp_q.push_back({2'b11, 8'h14});
        rst = 1'b0;
        tick(wr, rd, wv);
        e = exp_q.pop_front();
        total++;
        if (!(wr === 1'b1 && db_oe === 1'b1 && wv === e))
            $display("FAIL div_low: got wr=%b oe=%b %h required wr=1 oe=1 %h", wr, db_oe, wv, e);
        else passed++;
        tick(wr, rd, wv);
        e = exp_q.pop_front();
        total++;
        if (!(wr === 1'b1 && db_oe === 1'b1 && wv === e))
            $display("FAIL div_high: got wr=%b oe=%b %h required wr=1 oe=1 %h", wr, db_oe, wv, e);
        else passed++;
        tick(wr, rd, wv);
        total++;
        if ({iocs, iorw, ioaddr, db_oe, db_out} !== {1'b1, 1'b1, 2'b01, 1'b0, 8'h00})
            $display("FAIL first_poll: got %b required %b",
                     {iocs, iorw, ioaddr, db_oe, db_out}, {1'b1, 1'b1, 2'b01, 1'b0, 8'h00});
        else passed++;
    endtask

    task automatic test_echo();
        logic wr, rd;
        logic [9:0] wv, e;
        int n = 0;
        wr = 1'b0;
        rx_byte = 8'h41;
        rx_avail = 1'b1;
        tbr = 1'b1;
        exp_q.push_back({2'b00, 8'h41});
        for (int i = 0; i < 20; i++) begin
            tick(wr, rd, wv);
            n++;
            if (wr) break;
        end
        total++;
        if (!wr) $display("FAIL echo_timeout: got no write in %0d cycles required one", n);
        else passed++;
        e = exp_q.pop_front();
        total++;
        if (wv !== e) $display("FAIL echo_data: got %h required %h", wv, e);
        else passed++;
        total++;
        if (n != 4) $display("FAIL echo_latency: got %0d cycles required 4", n);
        else passed++;
        total++;
        if (echo_cnt !== 8'h01) $display("FAIL echo_cnt: got %h required 01", echo_cnt);
        else passed++;
    endtask

    task automatic test_tbr_stall();
        logic wr, rd;
        logic [9:0] wv, e;
        int writes = 0;
        logic bad_oe = 1'b0;
        rd = 1'b0;
        rx_byte = 8'h7E;
        rx_avail = 1'b1;
        tbr = 1'b0;
        exp_q.push_back({2'b00, 8'h7E});
        for (int i = 0; i < 10; i++) begin
            tick(wr, rd, wv);
            if (rd) break;
        end
        total++;
        if (!rd) $display("FAIL stall_read: got no rx read required one");
        else passed++;
        for (int i = 0; i < 20; i++) begin
            tick(wr, rd, wv);
            if (wr) writes++;
            if (db_oe !== 1'b0 || db_out !== 8'h00) bad_oe = 1'b1;
        end
        total++;
        if (writes != 0) $display("FAIL stall_nowrite: got %0d writes required 0", writes);
        else passed++;
        total++;
        if (bad_oe) $display("FAIL stall_oe: got db_oe/db_out active required 0/00");
        else passed++;
        total++;
        if ({iocs, iorw, ioaddr} !== 4'b1101)
            $display("FAIL stall_poll: got %b required 1101", {iocs, iorw, ioaddr});
        else passed++;
        tbr = 1'b1;
        tick(wr, rd, wv);
        total++;
        if (wr) $display("FAIL stall_early: got write %h required status poll", wv);
        else passed++;
        tick(wr, rd, wv);
        e = exp_q.pop_front();
        total++;
        if (!(wr === 1'b1 && wv === e)) $display("FAIL stall_write: got wr=%b %h required wr=1 %h", wr, wv, e);
        else passed++;
        total++;
        if (echo_cnt !== 8'h02) $display("FAIL stall_cnt: got %h required 02", echo_cnt);
        else passed++;
    endtask

    task automatic test_cfg_change();
        logic wr, rd;
        logic [9:0] wv, e;
        int writes = 0;
        rd = 1'b0;
        rx_avail = 1'b0;
        tick(wr, rd, wv);
        br_cfg = 2'b11;
        exp_q.push_back({2'b10, 8'h16});
        exp_q.push_back({2'b11, 8'h05});
        tick(wr, rd, wv);
        e = exp_q.pop_front();
        total++;
        if (!(wr === 1'b1 && wv === e)) $display("FAIL cfg_low: got wr=%b %h required wr=1 %h", wr, wv, e);
        else passed++;
        tick(wr, rd, wv);
        e = exp_q.pop_front();
        total++;
        if (!(wr === 1'b1 && wv === e)) $display("FAIL cfg_high: got wr=%b %h required wr=1 %h", wr, wv, e);
        else passed++;
        tick(wr, rd, wv);
        total++;
        if ({iocs, iorw, ioaddr} !== 4'b1101)
            $display("FAIL cfg_poll: got %b required 1101", {iocs, iorw, ioaddr});
        else passed++;

        rx_byte = 8'h3C;
        rx_avail = 1'b1;
        tbr = 1'b0;
        exp_q.push_back({2'b00, 8'h3C});
        for (int i = 0; i < 10; i++) begin
            tick(wr, rd, wv);
            if (rd) break;
        end
        total++;
        if (!rd) $display("FAIL defer_read: got no rx read required one");
        else passed++;
        br_cfg = 2'b10;
        for (int i = 0; i < 5; i++) begin
            tick(wr, rd, wv);
            if (wr) writes++;
        end
        total++;
        if (writes != 0) $display("FAIL defer_early: got %0d writes required 0", writes);
        else passed++;
        exp_q.push_back({2'b10, 8'h2C});
        exp_q.push_back({2'b11, 8'h0A});
        tbr = 1'b1;
        for (int i = 0; i < 20 && writes < 3; i++) begin
            tick(wr, rd, wv);
            if (wr) begin
                writes++;
                total++;
                if (exp_q.size() == 0) $display("FAIL defer_extra: got write %h required none", wv);
                else begin
                    e = exp_q.pop_front();
                    if (wv !== e) $display("FAIL defer_write: got %h required %h", wv, e);
                    else passed++;
                end
            end
        end
        total++;
        if (writes != 3) $display("FAIL defer_count: got %0d writes required 3", writes);
        else passed++;
        total++;
        if (echo_cnt !== 8'h03) $display("FAIL defer_cnt: got %h required 03", echo_cnt);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic wr, rd;
        logic [9:0] wv, e;
        int sent = 0;
        int writes = 0;
        rst = 1'b1;
        br_cfg = 2'b01;
        rx_avail = 1'b0;
        tbr = 1'b1;
        tick(wr, rd, wv);
        exp_q.delete();
        exp_q.push_back({2'b10, 8'h58});
        exp_q.push_back({2'b11, 8'h14});
        rst = 1'b0;
        for (int i = 0; i < 3000 && writes < 258; i++) begin
            if (!rx_avail && sent < 256) begin
                rx_byte = 8'($urandom);
                rx_avail = 1'b1;
                exp_q.push_back({2'b00, rx_byte});
                sent++;
            end
            tick(wr, rd, wv);
            if (wr) begin
                writes++;
                total++;
                if (exp_q.size() == 0) $display("FAIL b2b_extra: got write %h required none", wv);
                else begin
                    e = exp_q.pop_front();
                    if (wv !== e) $display("FAIL b2b_byte%0d: got %h required %h", writes, wv, e);
                    else passed++;
                end
                if (writes == 257) begin
                    total++;
                    if (echo_cnt !== 8'hFF) $display("FAIL b2b_cnt_ff: got %h required ff", echo_cnt);
                    else passed++;
                end
            end
        end
        total++;
        if (writes != 258) $display("FAIL b2b_count: got %0d writes required 258", writes);
        else passed++;
        total++;
        if (echo_cnt !== 8'h00) $display("FAIL b2b_wrap: got %h required 00", echo_cnt);
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic wr, rd;
        logic [9:0] wv, e;
        int writes = 0;
        rd = 1'b0;
        rx_byte = 8'hA5;
        rx_avail = 1'b1;
        tbr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(wr, rd, wv);
            if (rd) break;
        end
        total++;
        if (!rd) $display("FAIL mid_read: got no rx read required one");
        else passed++;
        for (int i = 0; i < 3; i++) tick(wr, rd, wv);
        rst = 1'b1;
        br_cfg = 2'b00;
        tick(wr, rd, wv);
        total++;
        if ({iocs, iorw, ioaddr, db_oe, db_out} !== {1'b0, 1'b1, 2'b00, 1'b0, 8'h00})
            $display("FAIL mid_bus: got %b required %b",
                     {iocs, iorw, ioaddr, db_oe, db_out}, {1'b0, 1'b1, 2'b00, 1'b0, 8'h00});
        else passed++;
        total++;
        if (echo_cnt !== 8'h00) $display("FAIL mid_cnt: got %h required 00", echo_cnt);
        else passed++;
        exp_q.delete();
        exp_q.push_back({2'b10, 8'hB1});
        exp_q.push_back({2'b11, 8'h28});
        tbr = 1'b1;
        rx_avail = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(wr, rd, wv);
            if (wr) begin
                writes++;
                total++;
                if (exp_q.size() == 0) $display("FAIL mid_extra: got write %h required none", wv);
                else begin
                    e = exp_q.pop_front();
                    if (wv !== e) $display("FAIL mid_write: got %h required %h", wv, e);
                    else passed++;
                end
            end
        end
        total++;
        if (writes != 2) $display("FAIL mid_count: got %0d writes required 2", writes);
        else passed++;
        total++;
        if (echo_cnt !== 8'h00) $display("FAIL mid_cnt_after: got %h required 00", echo_cnt);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_echo();
        test_tbr_stall();
        test_cfg_change();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/spart_driver.md
SPART_DRIVER -- requirements
Module: spart_driver

Interface
REQ-001 SHALL have parameter DIV_4800, default 16'h28B1, meaning divisor for br_cfg=00 (50 MHz clk).
REQ-002 SHALL have parameter DIV_9600, default 16'h1458, meaning divisor for br_cfg=01.
REQ-003 SHALL have parameter DIV_19200, default 16'h0A2C, meaning divisor for br_cfg=10.
REQ-004 SHALL have parameter DIV_38400, default 16'h0516, meaning divisor for br_cfg=11.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 br_cfg  input  2  baud select (DIP switches), may change at any time.
REQ-008 iocs  output  1  SPART chip select; one bus access per cycle it is high.
REQ-009 iorw  output  1  1 = read from SPART, 0 = write to SPART.
REQ-010 ioaddr  output  2  00 rx/tx buffer, 01 status, 10 divisor low, 11 divisor high.
REQ-011 db_out  output  8  write data toward SPART databus.
REQ-012 db_oe  output  1  drive enable for db_out onto the shared databus.
REQ-013 db_in  input  8  databus value seen by driver; valid in the same cycle as a read access.
REQ-014 echo_cnt  output  8  count of bytes echoed since reset.

Function
REQ-015 SHALL implement states INIT_LOW, INIT_HIGH, POLL_RX, READ_RX, POLL_TX, WRITE_TX.
REQ-016 SHALL, in INIT_LOW, drive iocs=1, iorw=0, ioaddr=10, db_oe=1, db_out=divisor[7:0], then go to INIT_HIGH.
REQ-017 SHALL, in INIT_HIGH, drive iocs=1, iorw=0, ioaddr=11, db_oe=1, db_out=divisor[15:8], then go to POLL_RX.
REQ-018 SHALL select divisor from the parameter table using cfg_q, a register loaded from br_cfg on entry to INIT_LOW.
REQ-019 SHALL, in POLL_RX, drive iocs=1, iorw=1, ioaddr=01, db_oe=0; go to READ_RX if db_in[0] (rda)=1, else stay.
REQ-020 SHALL, in POLL_RX, go to INIT_LOW instead when br_cfg != cfg_q, with priority over rda.
REQ-021 SHALL, in READ_RX, drive iocs=1, iorw=1, ioaddr=00, db_oe=0, capture db_in into rx_hold, go to POLL_TX.
REQ-022 SHALL, in POLL_TX, drive iocs=1, iorw=1, ioaddr=01, db_oe=0; go to WRITE_TX if db_in[1] (tbr)=1, else stay.
REQ-023 SHALL, in WRITE_TX, drive iocs=1, iorw=0, ioaddr=00, db_oe=1, db_out=rx_hold, increment echo_cnt, go to POLL_RX.
REQ-024 SHALL wrap echo_cnt from 8'hFF to 8'h00.
REQ-025 SHALL ignore br_cfg changes in READ_RX, POLL_TX, WRITE_TX; a pending change is acted on at the next POLL_RX.
REQ-026 SHALL drive db_oe=1 only when iocs=1 and iorw=0; db_out SHALL be 8'h00 whenever db_oe=0.
REQ-027 SHALL make all outputs registered-state decodes with no combinational path from db_in to any output.
REQ-028 SHALL ignore db_in[7:2] during status reads.
REQ-029 SHALL latency: reset release to first divisor-low write 1 cycle; rda seen to tx write minimum 3 cycles.

Reset
REQ-030 SHALL, on rst=1 at a clock edge, enter INIT_LOW, clear echo_cnt and rx_hold to 0, load cfg_q from br_cfg.
REQ-031 SHALL drive, during the reset cycle, iocs=0, iorw=1, ioaddr=00, db_oe=0, db_out=8'h00.
REQ-032 SHALL abandon any in-progress echo on reset mid-operation; the held byte is not transmitted.

Verification
REQ-033 Reset with br_cfg=01, release -> write 8'h58 @ ioaddr 10, next cycle 8'h14 @ ioaddr 11, then status polling.
REQ-034 Status db_in=8'h03 in POLL_RX, then db_in=8'h41 on READ_RX, status 8'h02 -> WRITE_TX writes 8'h41, echo_cnt=1.
REQ-035 Hold tbr=0 (status 8'h01) for 20 cycles after a read -> driver stays in POLL_TX, no write; tbr=1 -> write next cycle.
REQ-036 Change br_cfg 01->11 in POLL_RX -> next accesses write 8'h16 then 8'h05; change during POLL_TX -> deferred until echo done.
REQ-037 Echo 256 bytes back-to-back -> echo_cnt wraps to 8'h00; each tx byte equals corresponding rx byte.
REQ-038 Assert rst in POLL_TX holding 8'hA5 -> no write of 8'hA5, reprogramming restarts at INIT_LOW, echo_cnt=0.
